// File: rtl/mw_pkg.sv
// Shared opcodes, FSM state encoding and default geometry for the Microwire
// 93C46-class responder.
package mw_pkg;

   localparam int MW_ADDR_W    = 6;
   localparam int MW_DATA_W    = 16;
   localparam int MW_WR_CYCLES = 1000;

   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_ERASE = 2'b11;
   localparam logic [1:0] OP_EXT   = 2'b00;

   localparam logic [1:0] SUB_EWEN = 2'b11;
   localparam logic [1:0] SUB_EWDS = 2'b00;
   localparam logic [1:0] SUB_ERAL = 2'b10;
   localparam logic [1:0] SUB_WRAL = 2'b01;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      RDATA  = 3'd2,
      WDATA  = 3'd3,
      EXEC   = 3'd4,
      BUSY   = 3'd5,
      WAITCS = 3'd6
   } mw_state_e;

   typedef enum logic [1:0] {
      XOP_WRITE = 2'd0,
      XOP_ERASE = 2'd1,
      XOP_ERAL  = 2'd2,
      XOP_WRAL  = 2'd3
   } mw_xop_e;

endpackage

// File: rtl/mw_eeprom_responder_sync.sv
// Two-flop synchronizer for one asynchronous Microwire pin, plus a
// rising-edge pulse on the synchronized level.
module mw_sync_edge
   import mw_pkg::*;
(
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Synchronizer chain plus one delayed copy for edge detection.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign q_o    = sync_q;
   assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/mw_eeprom_responder.sv
// Microwire 93C46-class EEPROM responder: command decode, write-enable latch,
// self-timed busy. Define MW_SEQREAD_EN for sequential (auto-increment) reads.
module mw_eeprom_responder
   import mw_pkg::*;
#(
   parameter int ADDR_W    = MW_ADDR_W,
   parameter int DATA_W    = MW_DATA_W,
   parameter int WR_CYCLES = MW_WR_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mw_cs,
   input  logic mw_sk,
   input  logic mw_di,
   output logic mw_do,
   output logic mw_do_oe,
   output logic busy
);

   localparam int CMD_BITS = ADDR_W + 2;
   localparam int CNT_MAX  = (CMD_BITS > DATA_W) ? CMD_BITS : DATA_W;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int BCNT_W   = $clog2(WR_CYCLES + 1);

   localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(CMD_BITS - 1);
   localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]  DATA_DONE = CNT_W'(DATA_W);
   localparam logic [BCNT_W-1:0] BUSY_LAST = BCNT_W'(WR_CYCLES - 1);

   logic cs_s, di_s, sk_rise_s;
   logic sk_lvl_unused_s, cs_rise_unused_s, di_rise_unused_s;

   mw_sync_edge u_sync_cs (.clk_i(clk), .rst_n_i(rst_n), .d_i(mw_cs), .q_o(cs_s),            .rise_o(cs_rise_unused_s));
   mw_sync_edge u_sync_sk (.clk_i(clk), .rst_n_i(rst_n), .d_i(mw_sk), .q_o(sk_lvl_unused_s), .rise_o(sk_rise_s));
   mw_sync_edge u_sync_di (.clk_i(clk), .rst_n_i(rst_n), .d_i(mw_di), .q_o(di_s),            .rise_o(di_rise_unused_s));

   mw_state_e           state_q, state_d;
   mw_xop_e             xop_q, xop_d;
   logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
   logic [CMD_BITS-2:0] shift_q, shift_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
   logic                armed_q, armed_d;
   logic                wen_q, wen_d;
   logic                status_q, status_d;
   logic                do_q, do_d;
   logic                oe_q, oe_d;
   logic                busy_q, busy_d;
   logic                mem_we_s;

   logic [DATA_W-1:0]   mem_q [2**ADDR_W];

   logic [CMD_BITS-1:0] cmd_full_s;
   logic [1:0]          cmd_op_s;
   logic [ADDR_W-1:0]   cmd_addr_s;
   logic [1:0]          cmd_sub_s;
   logic [DATA_W-1:0]   rd_word_s;
   logic                bulk_s;
   logic [DATA_W-1:0]   wr_word_s;

   // The final address bit is still on di_s, so decode sees the complete command.
   assign cmd_full_s = {shift_q, di_s};
   assign cmd_op_s   = cmd_full_s[CMD_BITS-1 -: 2];
   assign cmd_addr_s = cmd_full_s[ADDR_W-1:0];
   assign cmd_sub_s  = cmd_addr_s[ADDR_W-1 -: 2];
   assign rd_word_s  = mem_q[cmd_addr_s];
   assign bulk_s     = (xop_q == XOP_ERAL) || (xop_q == XOP_WRAL);
   assign wr_word_s  = ((xop_q == XOP_ERASE) || (xop_q == XOP_ERAL)) ? {DATA_W{1'b1}} : data_q;

`ifdef MW_SEQREAD_EN
   logic [ADDR_W-1:0] nxt_addr_s;
   logic [DATA_W-1:0] nxt_word_s;
   assign nxt_addr_s = addr_q + 1'b1;
   assign nxt_word_s = mem_q[nxt_addr_s];
`endif

   // Next-state and output decode for the command FSM.
   always_comb begin
      state_d  = state_q;
      xop_d    = xop_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      addr_d   = addr_q;
      data_d   = data_q;
      bcnt_d   = bcnt_q;
      armed_d  = armed_q;
      wen_d    = wen_q;
      status_d = status_q;
      do_d     = do_q;
      oe_d     = oe_q;
      busy_d   = busy_q;
      mem_we_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (!cs_s) begin
               oe_d = 1'b0;
               do_d = 1'b0;
            end else if (sk_rise_s && di_s) begin
               state_d  = CMD;
               bitcnt_d = '0;
               status_d = 1'b0;
               armed_d  = 1'b0;
               oe_d     = 1'b0;
               do_d     = 1'b0;
            end else begin
               oe_d = status_q;
               do_d = status_q;
            end
         end
         CMD: begin
            if (!cs_s) begin
               state_d = IDLE;
               oe_d    = 1'b0;
               do_d    = 1'b0;
            end else if (sk_rise_s) begin
               shift_d  = cmd_full_s[CMD_BITS-2:0];
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == CMD_LAST) begin
                  bitcnt_d = '0;
                  addr_d   = cmd_addr_s;
                  case (cmd_op_s)
                     OP_READ: begin
                        state_d = RDATA;
                        oe_d    = 1'b1;
                        do_d    = 1'b0;
                        data_d  = rd_word_s;
                     end
                     OP_WRITE: begin
                        state_d = WDATA;
                        xop_d   = XOP_WRITE;
                     end
                     OP_ERASE: begin
                        state_d = WAITCS;
                        xop_d   = XOP_ERASE;
                        armed_d = 1'b1;
                     end
                     OP_EXT: begin
                        case (cmd_sub_s)
                           SUB_EWEN: begin
                              wen_d   = 1'b1;
                              state_d = WAITCS;
                           end
                           SUB_EWDS: begin
                              wen_d   = 1'b0;
                              state_d = WAITCS;
                           end
                           SUB_ERAL: begin
                              state_d = WAITCS;
                              xop_d   = XOP_ERAL;
                              armed_d = 1'b1;
                           end
                           default: begin
                              state_d = WDATA;
                              xop_d   = XOP_WRAL;
                           end
                        endcase
                     end
                     default: state_d = IDLE;
                  endcase
               end else begin
                  addr_d = addr_q;
               end
            end else begin
               shift_d = shift_q;
            end
         end
         RDATA: begin
            if (!cs_s) begin
               state_d = IDLE;
               oe_d    = 1'b0;
               do_d    = 1'b0;
            end else if (sk_rise_s) begin
               if (bitcnt_q != DATA_DONE) begin
                  do_d     = data_q[DATA_W-1];
                  data_d   = {data_q[DATA_W-2:0], 1'b0};
                  bitcnt_d = bitcnt_q + 1'b1;
               end else begin
`ifdef MW_SEQREAD_EN
                  // Next word follows immediately: its MSB replaces the dummy slot.
                  addr_d   = nxt_addr_s;
                  do_d     = nxt_word_s[DATA_W-1];
                  data_d   = {nxt_word_s[DATA_W-2:0], 1'b0};
                  bitcnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
`else
                  do_d    = 1'b0;
                  state_d = WAITCS;
`endif
               end
            end else begin
               do_d = do_q;
            end
         end
         WDATA: begin
            if (!cs_s) begin
               state_d = IDLE;
               oe_d    = 1'b0;
               do_d    = 1'b0;
            end else if (sk_rise_s) begin
               data_d   = {data_q[DATA_W-2:0], di_s};
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == DATA_LAST) begin
                  state_d = WAITCS;
                  armed_d = 1'b1;
               end else begin
                  armed_d = 1'b0;
               end
            end else begin
               data_d = data_q;
            end
         end
         WAITCS: begin
            if (!cs_s) begin
               state_d = armed_q ? EXEC : IDLE;
               oe_d    = 1'b0;
               do_d    = 1'b0;
            end else begin
               state_d = WAITCS;
            end
         end
         EXEC: begin
            armed_d = 1'b0;
            oe_d    = 1'b0;
            do_d    = 1'b0;
            if (wen_q) begin
               mem_we_s = 1'b1;
               bcnt_d   = '0;
               busy_d   = 1'b1;
               state_d  = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            oe_d = cs_s;
            do_d = 1'b0;
            if (bcnt_q == BUSY_LAST) begin
               bcnt_d   = '0;
               busy_d   = 1'b0;
               status_d = 1'b1;
               state_d  = IDLE;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            oe_d    = 1'b0;
            do_d    = 1'b0;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         xop_q    <= XOP_WRITE;
         bitcnt_q <= '0;
         shift_q  <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         bcnt_q   <= '0;
         armed_q  <= 1'b0;
         wen_q    <= 1'b0;
         status_q <= 1'b0;
         do_q     <= 1'b0;
         oe_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         xop_q    <= xop_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         bcnt_q   <= bcnt_d;
         armed_q  <= armed_d;
         wen_q    <= wen_d;
         status_q <= status_d;
         do_q     <= do_d;
         oe_q     <= oe_d;
         busy_q   <= busy_d;
      end
   end

   // Storage array: committed only from EXEC and deliberately not reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
         if (mem_we_s && (bulk_s || (ADDR_W'(i) == addr_q))) begin
            mem_q[i] <= wr_word_s;
         end
      end
   end

   assign mw_do    = do_q;
   assign mw_do_oe = oe_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_mw_eeprom_responder.sv
// Scoreboard bench for mw_eeprom_responder: stimulus queues expected DO/OE per
// SK pulse and expected busy lengths; monitors pop and compare.
module tb_mw_eeprom_responder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mw_cs = 1'b0;
   logic mw_sk = 1'b0;
   logic mw_di = 1'b0;
   logic mw_do, mw_do_oe, busy;

   always #5 clk = ~clk;

   mw_eeprom_responder dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mw_cs    (mw_cs),
      .mw_sk    (mw_sk),
      .mw_di    (mw_di),
      .mw_do    (mw_do),
      .mw_do_oe (mw_do_oe),
      .busy     (busy)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int pulse_no = 0;
   int bcnt = 0;
   logic st_pend = 1'b0;

   // Each entry: {check_enable, expected_do, expected_oe}.
   logic [2:0] do_exp_q [$];
   int         busy_exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // DO monitor: the host samples DO at each SK rising edge.
   initial begin
      forever begin
         logic [2:0] e;
         int sz;
         @(posedge mw_sk);
         pulse_no++;
         sz = do_exp_q.size();
         if (sz == 0) begin
            check($sformatf("sk_pulse_%0d_expected", pulse_no), sz, 1);
         end else begin
            e = do_exp_q.pop_front();
            if (e[2]) begin
               check($sformatf("mw_do@pulse%0d", pulse_no), mw_do, e[1]);
               check($sformatf("mw_do_oe@pulse%0d", pulse_no), mw_do_oe, e[0]);
            end
         end
      end
   end

   // Busy monitor: measures each busy pulse in clk cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (busy === 1'b1) begin
            bcnt++;
         end else if (bcnt != 0) begin
            if (busy_exp_q.size() == 0) check("busy_unexpected_len", bcnt, 0);
            else check("busy_len", bcnt, busy_exp_q.pop_front());
            bcnt = 0;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic sk_bit(input logic d, input logic c, input logic ed, input logic eo);
      do_exp_q.push_back({c, ed, eo});
      mw_di = d;
      repeat (4) @(negedge clk);
      mw_sk = 1'b1;
      repeat (8) @(negedge clk);
      mw_sk = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_low();
      mw_cs = 1'b0;
      mw_di = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   // One leading zero, start bit, opcode, address. Pending ready status shows
   // DO=1 up to and including the start-bit sample.
   task automatic send_cmd(input logic [1:0] op, input logic [5:0] a);
      mw_cs = 1'b1;
      repeat (4) @(negedge clk);
      sk_bit(1'b0, 1'b1, st_pend, st_pend);
      sk_bit(1'b1, 1'b1, st_pend, st_pend);
      st_pend = 1'b0;
      for (int i = 1; i >= 0; i--) sk_bit(op[i], 1'b1, 1'b0, 1'b0);
      for (int i = 5; i >= 0; i--) sk_bit(a[i], 1'b1, 1'b0, 1'b0);
   endtask

   task automatic send_data(input logic [15:0] d, input int nbits);
      for (int i = 15; i >= 16 - nbits; i--) sk_bit(d[i], 1'b1, 1'b0, 1'b0);
   endtask

   task automatic read_word(input logic [5:0] a, input logic [15:0] e);
      send_cmd(2'b10, a);
      sk_bit(1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 15; i >= 0; i--) sk_bit(1'b0, 1'b1, e[i], 1'b1);
`ifndef MW_SEQREAD_EN
      sk_bit(1'b0, 1'b1, 1'b0, 1'b1);
      sk_bit(1'b0, 1'b1, 1'b0, 1'b1);
`endif
      cs_low();
   endtask

   task automatic write_word(input logic [5:0] a, input logic [15:0] d, input logic exp_busy);
      send_cmd(2'b01, a);
      send_data(d, 16);
      if (exp_busy) begin
         busy_exp_q.push_back(1000);
         st_pend = 1'b1;
      end
      cs_low();
      repeat (1100) @(negedge clk);
   endtask

   initial begin
      int found;
      repeat (5) @(negedge clk);
      check("reset_do", mw_do, 1'b0);
      check("reset_oe", mw_do_oe, 1'b0);
      check("reset_busy", busy, 1'b0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // EWEN, then WRITE 0x05 = 0xA5C3 with DO probed during busy
      send_cmd(2'b00, 6'b110000);
      cs_low();
      send_cmd(2'b01, 6'h05);
      send_data(16'hA5C3, 16);
      busy_exp_q.push_back(1000);
      st_pend = 1'b1;
      cs_low();
      repeat (14) @(negedge clk);
      mw_cs = 1'b1;
      repeat (4) @(negedge clk);
      for (int k = 0; k < 3; k++) sk_bit(1'b0, 1'b1, 1'b0, 1'b1);
      cs_low();
      repeat (1100) @(negedge clk);
      read_word(6'h05, 16'hA5C3);

      // EWDS blocks writes
      send_cmd(2'b00, 6'b000000);
      cs_low();
      write_word(6'h05, 16'h0000, 1'b0);
      read_word(6'h05, 16'hA5C3);

      // EWEN, ERASE, WRAL
      send_cmd(2'b00, 6'b110000);
      cs_low();
      send_cmd(2'b11, 6'h05);
      busy_exp_q.push_back(1000);
      st_pend = 1'b1;
      cs_low();
      repeat (1100) @(negedge clk);
      read_word(6'h05, 16'hFFFF);
      send_cmd(2'b00, 6'b010000);
      send_data(16'h1234, 16);
      busy_exp_q.push_back(1000);
      st_pend = 1'b1;
      cs_low();
      repeat (1100) @(negedge clk);
      read_word(6'h00, 16'h1234);
      read_word(6'h3F, 16'h1234);

      // WRITE aborted after 8 data bits
      send_cmd(2'b01, 6'h05);
      send_data(16'hBEEF, 8);
      cs_low();
      repeat (50) @(negedge clk);
      read_word(6'h05, 16'h1234);

      // Reset 100 cycles into busy of a valid write
      send_cmd(2'b01, 6'h05);
      send_data(16'h5A5A, 16);
      busy_exp_q.push_back(100);
      mw_cs = 1'b0;
      mw_di = 1'b0;
      found = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (busy === 1'b1) begin
            found = 1;
            break;
         end
      end
      check("busy_rise_seen", found, 1);
      if (found == 1) begin
         repeat (99) @(negedge clk);
         rst_n = 1'b0;
         @(negedge clk);
         check("busy_after_reset", busy, 1'b0);
         rst_n = 1'b1;
      end
      repeat (10) @(negedge clk);
      read_word(6'h05, 16'h5A5A);

`ifdef MW_SEQREAD_EN
      // Sequential read across the address wrap
      send_cmd(2'b00, 6'b110000);
      cs_low();
      write_word(6'h3F, 16'hC00F, 1'b1);
      write_word(6'h00, 16'h0FF0, 1'b1);
      begin
         logic [31:0] two;
         two = {16'hC00F, 16'h0FF0};
         send_cmd(2'b10, 6'h3F);
         sk_bit(1'b0, 1'b1, 1'b0, 1'b1);
         for (int i = 31; i >= 0; i--) sk_bit(1'b0, 1'b1, two[i], 1'b1);
         cs_low();
      end
`endif

      repeat (20) @(negedge clk);
      check("do_queue_drained", do_exp_q.size(), 0);
      check("busy_queue_drained", busy_exp_q.size(), 0);
      check("busy_idle_at_end", bcnt, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
